patp_fetch_unit: RTL

Instruction fetch stage of the PATP core, directly upstream of the fetch/execute phase flip-flop.
- Holds the program counter and issues a read request to program memory.
- Latches the returned word into the instruction register.
- Pulses `fetch_done` to drive the flip-flop's `trigger_set` input.
- Monitors the flip-flop's `q` output (`in_execute`) so it never refetches while the execute stage owns the machine.

---
 rtl/patp_fetch_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/patp_fetch_unit.sv
// patp_fetch_unit: instruction fetch stage of the PATP core.
// Holds the program counter, requests program memory, latches the returned
// word into the instruction register and pulses fetch_done towards the
// fetch/execute phase flip-flop. It stays idle while in_execute is high.
// Optional build macro: FETCH_TIMEOUT_EN adds an ack watchdog with a sticky
// fetch_err flag. Without the macro, fetch waits for an ack indefinitely.
module patp_fetch_unit #(
  parameter int ADDR_W         = 5,
  parameter int INSTR_W        = 8,
  parameter int OPCODE_W       = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_execute,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_rd_req,
  input  logic                        mem_rd_ack,
  input  logic [INSTR_W-1:0]          mem_rd_data,
  output logic [INSTR_W-1:0]          ir,
  output logic [OPCODE_W-1:0]         opcode,
  output logic [INSTR_W-OPCODE_W-1:0] operand,
  output logic                        fetch_done,
  output logic [ADDR_W-1:0]           pc,
  input  logic                        pc_load,
  input  logic [ADDR_W-1:0]           pc_load_val,
  input  logic                        halt,
  output logic                        halted,
  output logic                        fetch_err
);

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_ISSUE,
    S_WAIT_SET,
    S_EXEC,
    S_HALT
  } state_t;

  state_t state;

  // A watchdog limit of zero would make every fetch fail immediately.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("patp_fetch_unit: TIMEOUT_CYCLES must be at least 1");
  end

  assign mem_addr = pc;
  assign opcode   = ir[INSTR_W-1 -: OPCODE_W];
  assign operand  = ir[INSTR_W-OPCODE_W-1:0];

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign fetch_err = 1'b0;
`endif

  // Fetch sequencer: every output except the ir slices is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_START;
      pc         <= '0;
      ir         <= '0;
      mem_rd_req <= 1'b0;
      fetch_done <= 1'b0;
      halted     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt   <= '0;
      fetch_err  <= 1'b0;
`endif
    end else begin
      fetch_done <= 1'b0;
      case (state)
        S_START: begin
          state      <= S_FETCH;
          mem_rd_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt   <= '0;
`endif
        end
        S_FETCH: begin
          // An ack in the same cycle the watchdog expires still wins.
          if (mem_rd_ack) begin
            ir         <= mem_rd_data;
            pc         <= pc + ADDR_W'(1);
            mem_rd_req <= 1'b0;
            fetch_done <= 1'b1;
            state      <= S_ISSUE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem_rd_req <= 1'b0;
            fetch_err  <= 1'b1;
            halted     <= 1'b1;
            state      <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        S_ISSUE: begin
          state <= S_WAIT_SET;
        end
        S_WAIT_SET: begin
          // The phase flip-flop takes one cycle to show the set.
          if (in_execute) begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (pc_load) begin
            pc <= pc_load_val;
          end
          if (!in_execute) begin
            if (halt) begin
              halted     <= 1'b1;
              mem_rd_req <= 1'b0;
              state      <= S_HALT;
            end else begin
              mem_rd_req <= 1'b1;
              state      <= S_FETCH;
`ifdef FETCH_TIMEOUT_EN
              wait_cnt   <= '0;
`endif
            end
          end
        end
        S_HALT: begin
          halted     <= 1'b1;
          mem_rd_req <= 1'b0;
        end
        default: begin
          state <= S_START;
        end
      endcase
    end
  end

endmodule
